// File: rtl/prime_collector.sv
// ---------------------------------------------------------------------------
// prime_collector
//
// Collects primes reported by an upstream prime checker into a
// first-word-fall-through FIFO and keeps running statistics on the stream
// of primes: primes lost to overflow, twin-prime pairs, and (optionally)
// the largest gap between consecutive primes.
//
// Optional feature macro: PRIME_GAP_EN
//   defined   -> max_gap tracks the largest difference between consecutive
//                increasing primes
//   undefined -> max_gap is tied to 0 and no gap logic exists
//
// Parameters
//   WIDTH  bit width of checked numbers and of all counters
//   DEPTH  FIFO entries (power of two, >= 2)
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_num     number just checked upstream
//   in_prime   upstream prime flag for in_num
//   in_valid   in_num/in_prime carry a new result this cycle
//   out_data   FIFO head prime
//   out_valid  out_data valid (FIFO not empty)
//   out_ready  consumer accepts out_data
//   full       FIFO holds DEPTH entries
//   empty      FIFO holds 0 entries
//   count      current FIFO occupancy
//   drop_cnt   primes lost to overflow, saturating
//   twin_cnt   twin-prime pairs seen, saturating
//   max_gap    largest difference between consecutive primes
// ---------------------------------------------------------------------------
module prime_collector #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_num,
    input  logic                     in_prime,
    input  logic                     in_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         drop_cnt,
    output logic [WIDTH-1:0]         twin_cnt,
    output logic [WIDTH-1:0]         max_gap
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        NOSEQ = 1'b0,  // no previous prime held
        TRACK = 1'b1   // last_prime_q holds the previous prime
    } track_state_e;

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    // Tracker state
    track_state_e     state_q, state_d;
    logic [WIDTH-1:0] last_prime_q, last_prime_d;
    logic [WIDTH-1:0] twin_cnt_q, twin_cnt_d;
    logic [WIDTH-1:0] diff;

    logic prime_ev;
    logic push;
    logic pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign out_valid = ~empty;
    assign count     = count_q;
    assign drop_cnt  = drop_cnt_q;
    assign twin_cnt  = twin_cnt_q;
    assign out_data  = mem_q[rd_ptr_q];

    assign prime_ev = in_valid & in_prime;
    assign pop      = out_valid & out_ready;
    // A full FIFO still accepts a prime when the head leaves in the same cycle.
    assign push     = prime_ev & (~full | pop);
    assign diff     = in_num - last_prime_q;

    // NOTE: every variable gets a default at the top of a combinational block
    // so no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;

        // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        if (prime_ev && full && !pop && drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + WIDTH'(1);
        end
    end

    // Tracker sees every prime event, whether or not the FIFO accepted it.
    always_comb begin
        state_d      = state_q;
        last_prime_d = last_prime_q;
        twin_cnt_d   = twin_cnt_q;

        if (prime_ev) begin
            last_prime_d = in_num;
            state_d      = TRACK;
            // A non-increasing number means upstream restarted: re-seed only.
            if (state_q == TRACK && in_num > last_prime_q) begin
                if (diff == WIDTH'(2) && twin_cnt_q != '1) begin
                    twin_cnt_d = twin_cnt_q + WIDTH'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            drop_cnt_q   <= '0;
            state_q      <= NOSEQ;
            last_prime_q <= '0;
            twin_cnt_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drop_cnt_q   <= drop_cnt_d;
            state_q      <= state_d;
            last_prime_q <= last_prime_d;
            twin_cnt_q   <= twin_cnt_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after it
    // was written, and omitting the reset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_num;
    end

`ifdef PRIME_GAP_EN
    logic [WIDTH-1:0] max_gap_q, max_gap_d;

    always_comb begin
        max_gap_d = max_gap_q;
        if (prime_ev && state_q == TRACK && in_num > last_prime_q && diff > max_gap_q) begin
            max_gap_d = diff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) max_gap_q <= '0;
        else     max_gap_q <= max_gap_d;
    end

    assign max_gap = max_gap_q;
`else
    assign max_gap = '0;
`endif

endmodule

// File: tb/tb_prime_collector.sv
// ---------------------------------------------------------------------------
// tb_prime_collector
//
// Self-checking bench for prime_collector (DEPTH=4, WIDTH=11). A queue-based
// reference model tracks the expected FIFO contents and statistics; a compare
// process checks every output on each falling edge. Directed scenarios pin
// the model with hand-computed streams and counter values, then randomized
// traffic and a long saturation run follow.
// ---------------------------------------------------------------------------
module tb_prime_collector;

    localparam int WIDTH = 11;
    localparam int DEPTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef PRIME_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_num;
    logic             in_prime;
    logic             in_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             full;
    logic             empty;
    logic [2:0]       count;
    logic [WIDTH-1:0] drop_cnt;
    logic [WIDTH-1:0] twin_cnt;
    logic [WIDTH-1:0] max_gap;

    prime_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_num    (in_num),
        .in_prime  (in_prime),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .drop_cnt  (drop_cnt),
        .twin_cnt  (twin_cnt),
        .max_gap   (max_gap)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int q[$];
    int m_drop, m_twin, m_gap, m_last;
    bit m_have;
    bit m_ok = 1'b0;

    always @(posedge clk) begin : model
        bit m_pop;
        bit m_pe;
        int sz;
        int d;
        if (rst) begin
            q.delete();
            m_drop = 0; m_twin = 0; m_gap = 0; m_last = 0;
            m_have = 1'b0;
            m_ok   = 1'b1;
        end else if (m_ok) begin
            sz    = q.size();
            m_pop = (sz > 0) && out_ready;
            m_pe  = in_valid && in_prime;
            if (m_pop) void'(q.pop_front());
            if (m_pe) begin
                if (sz < DEPTH || m_pop) q.push_back(int'(in_num));
                else if (m_drop < MAXV) m_drop++;
                if (m_have && int'(in_num) > m_last) begin
                    d = int'(in_num) - m_last;
                    if (d == 2 && m_twin < MAXV) m_twin++;
                    if (GAP_EN && d > m_gap) m_gap = d;
                end
                m_last = int'(in_num);
                m_have = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("out_valid", out_valid, q.size() != 0);
            check("empty",     empty,     q.size() == 0);
            check("full",      full,      q.size() == DEPTH);
            check("count",     count,     q.size());
            check("drop_cnt",  drop_cnt,  m_drop);
            check("twin_cnt",  twin_cnt,  m_twin);
            check("max_gap",   max_gap,   m_gap);
            if (q.size() != 0) check("out_data", out_data, q[0]);
        end
    end

    // Values actually handed to the consumer, for the directed scenarios.
    int dut_stream[$];
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) dut_stream.push_back(int'(out_data));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic v, input logic p, input int n, input logic r);
        in_valid  = v;
        in_prime  = p;
        in_num    = WIDTH'(n);
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 0, 1'b0);
        rst = 1'b0;
        dut_stream.delete();
    endtask

    task automatic idle(input int cycles, input logic r);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 0, r);
    endtask

    task automatic check_stream(input string name, input int exp[$]);
        check({name, "_len"}, dut_stream.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            check(name, (i < dut_stream.size()) ? dut_stream[i] : -1, exp[i]);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int k = 2; k * k <= n; k++) if (n % k == 0) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int num;
        int bias;
        int exp_a[$] = '{2, 3, 5, 7, 11, 13, 17, 19};
        int exp_b[$] = '{2, 3, 5, 7};
        int exp_c[$] = '{2, 3, 5, 7, 13};
        int exp_d[$] = '{17, 19, 2, 3};
        int pb[$]    = '{2, 3, 5, 7};

        rst = 1'b1; in_valid = 1'b0; in_prime = 1'b0; in_num = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_empty", empty, 1'b1);
        check("reset_count", count, 0);
        check("reset_valid", out_valid, 1'b0);

        // Numbers 0..20 with correct flags, consumer always ready.
        do_reset();
        for (int n = 0; n <= 20; n++) step(1'b1, is_prime(n), n, 1'b1);
        idle(3, 1'b1);
        check_stream("streamA", exp_a);
        check("A_twin", twin_cnt, 4);
        check("A_gap",  max_gap, GAP_EN ? 4 : 0);
        check("A_drop", drop_cnt, 0);

        // Overflow: 2,3,5,7 fill, 11 dropped but still tracked.
        do_reset();
        foreach (pb[i]) step(1'b1, 1'b1, pb[i], 1'b0);
        check("B_full",  full, 1'b1);
        check("B_count", count, 4);
        step(1'b1, 1'b1, 11, 1'b0);
        check("B_drop",  drop_cnt, 1);
        idle(6, 1'b1);
        check_stream("streamB", exp_b);
        check("B_empty", empty, 1'b1);
        check("B_twin",  twin_cnt, 2);
        check("B_gap",   max_gap, GAP_EN ? 4 : 0);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        foreach (pb[i]) step(1'b1, 1'b1, pb[i], 1'b0);
        check("C_full", full, 1'b1);
        step(1'b1, 1'b1, 13, 1'b1);
        check("C_count", count, 4);
        check("C_drop",  drop_cnt, 0);
        idle(6, 1'b1);
        check_stream("streamC", exp_c);

        // Upstream restart after 17,19.
        do_reset();
        step(1'b1, 1'b1, 17, 1'b1);
        step(1'b1, 1'b1, 19, 1'b1);
        step(1'b1, 1'b1, 2, 1'b1);
        step(1'b1, 1'b1, 3, 1'b1);
        idle(3, 1'b1);
        check_stream("streamD", exp_d);
        check("D_twin", twin_cnt, 1);
        check("D_gap",  max_gap, GAP_EN ? 2 : 0);

        // Reset with count=3 and a simultaneous prime event.
        do_reset();
        step(1'b1, 1'b1, 2, 1'b0);
        step(1'b1, 1'b1, 3, 1'b0);
        step(1'b1, 1'b1, 5, 1'b0);
        check("E_count3", count, 3);
        rst = 1'b1;
        step(1'b1, 1'b1, 7, 1'b1);
        rst = 1'b0;
        check("E_count", count, 0);
        check("E_empty", empty, 1'b1);
        check("E_full",  full, 1'b0);
        check("E_valid", out_valid, 1'b0);
        check("E_drop",  drop_cnt, 0);
        check("E_twin",  twin_cnt, 0);
        check("E_gap",   max_gap, 0);
        // A tracker left in TRACK with last_prime=0 would count 0->2 as a twin.
        step(1'b1, 1'b1, 2, 1'b0);
        check("E_noseq_twin", twin_cnt, 0);
        step(1'b1, 1'b1, 3, 1'b0);
        step(1'b1, 1'b1, 5, 1'b0);
        check("E_twin35", twin_cnt, 1);
        check("E_gap35",  max_gap, GAP_EN ? 2 : 0);

        // Randomized traffic with alternating consumer pressure.
        do_reset();
        num  = 1;
        bias = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) bias = $urandom_range(0, 3);
            if ($urandom_range(0, 29) == 0) num = $urandom_range(0, 20);
            else num = (num + $urandom_range(1, 4)) % (MAXV + 1);
            rst = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), num,
                 $urandom_range(0, 3) < bias);
            rst = 1'b0;
        end

        // Saturation: alternating 1,3 yields a twin every other event and
        // restarts in between; the stalled FIFO drops nearly every prime.
        do_reset();
        for (int i = 0; i < 4200; i++) step(1'b1, 1'b1, (i % 2 == 0) ? 1 : 3, 1'b0);
        check("S_drop", drop_cnt, MAXV);
        check("S_twin", twin_cnt, MAXV);
        check("S_gap",  max_gap, GAP_EN ? 2 : 0);
        idle(6, 1'b1);
        check("S_empty", empty, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prime_collector.md
PRIME_COLLECTOR -- requirements
Module: prime_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 11, bit width of checked numbers and of all counters.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_num  input  WIDTH  number just checked, driven by the upstream prime checker's numberChecked.
REQ-006 SHALL have port in_prime  input  1  upstream prime flag for in_num.
REQ-007 SHALL have port in_valid  input  1  in_num/in_prime are a new result this cycle.
REQ-008 SHALL have port out_data  output  WIDTH  FIFO head prime.
REQ-009 SHALL have port out_valid  output  1  out_data valid, equal to not empty.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-011 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-012 SHALL have port empty  output  1  FIFO holds 0 entries.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 SHALL have port drop_cnt  output  WIDTH  primes lost to overflow, saturating.
REQ-015 SHALL have port twin_cnt  output  WIDTH  twin-prime pairs seen, saturating.
REQ-016 SHALL have port max_gap  output  WIDTH  largest difference between consecutive primes.

Function
REQ-017 SHALL define a prime event as a cycle with in_valid=1 and in_prime=1; cycles with in_valid=0 or in_prime=0 SHALL change nothing.
REQ-018 SHALL define push as a prime event with either full=0 or a simultaneous pop, and pop as out_valid=1 with out_ready=1.
REQ-019 SHALL be first-word-fall-through: a value pushed into an empty FIFO appears on out_data with out_valid=1 in the cycle after the push edge.
REQ-020 SHALL deliver primes in arrival order, with no duplication.
REQ-021 SHALL, on a simultaneous push and pop, leave count unchanged, including when full=1; no drop SHALL occur in that case.
REQ-022 SHALL, on a prime event while full=1 with no pop, discard in_num and increment drop_cnt, saturating at all-ones.
REQ-023 SHALL ignore a pop while empty; count SHALL never go below 0 or above DEPTH.
REQ-024 SHALL wrap read and write pointers modulo DEPTH.
REQ-025 SHALL implement a tracker FSM with states NOSEQ (no previous prime held) and TRACK (last_prime held).
REQ-026 SHALL, in NOSEQ on a prime event, store last_prime=in_num and move to TRACK; no twin or gap update SHALL occur.
REQ-027 SHALL, in TRACK on a prime event with in_num > last_prime, compute diff = in_num - last_prime (WIDTH bits) and store last_prime=in_num.
REQ-028 SHALL, in that case, increment twin_cnt (saturating) when diff==2.
REQ-029 SHALL, in TRACK on a prime event with in_num <= last_prime (upstream restart), store last_prime=in_num and stay in TRACK, with no twin or gap update.
REQ-030 SHALL let the tracker observe every prime event, including dropped ones.

Reset
REQ-031 SHALL, when rst=1 at a clk edge, clear both pointers, count=0, empty=1, full=0, out_valid=0, drop_cnt=0, twin_cnt=0, max_gap=0, last_prime=0, and set the FSM to NOSEQ.
REQ-032 SHALL let reset override any simultaneous push or pop; FIFO contents are lost and out_data is don't-care while empty.

Configuration
REQ-033 SHALL use macro PRIME_GAP_EN: when defined, in TRACK with in_num > last_prime, set max_gap=diff whenever diff > max_gap.
REQ-034 SHALL, with PRIME_GAP_EN undefined, keep the max_gap port present but tie it to constant 0 and synthesize no gap logic.

Verification
REQ-035 SHALL cover: in_valid=1, numbers 0..20 in order with correct prime flags, out_ready=1 -> out stream 2,3,5,7,11,13,17,19; twin_cnt=4; max_gap=4 (0 without the macro); drop_cnt=0.
REQ-036 SHALL cover: DEPTH=4, out_ready=0, primes 2,3,5,7,11 -> full=1 after the 4th; drop_cnt=1; then out_ready=1 -> 2,3,5,7, then empty=1; twin_cnt=2 (3-5, 5-7); max_gap=4 (7 to 11, tracker still sees the dropped 11).
REQ-037 SHALL cover: DEPTH=4 with full=1, prime 13 presented with out_ready=1 -> count stays 4, drop_cnt unchanged, 13 is last in the out stream.
REQ-038 SHALL cover: after 17,19 then restart input 2,3 -> twin_cnt increments only for 17-19; no gap update for 19 to 2; diff 3-2=1 not counted as a twin.
REQ-039 SHALL cover: rst=1 for one cycle with count=3 and a simultaneous prime event -> next cycle count=0, empty=1, all counters 0, FSM NOSEQ.
